piso_frame_tx: RTL and testbench
================================

# piso_frame_tx

Parallel-in, serial-out frame transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and serializes it onto a single line as start bit, data bits, optional even-parity bit, then stop bit. It is the transmit end of the team's serial shift-register link: its line output drives the serial input of the downstream shift/receive chain. Back-to-back frames are supported with no idle gap.

## Interface
- WIDTH, 4, data word width; legal values are 2 to 32.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.
- MSB_FIRST, 0, 0 sends the LSB first; 1 sends the MSB first.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  transmitter can accept a word this cycle.
- serial_out  output  1  line output; idles high (mark).
- busy  output  1  a frame is on the line (START through STOP).
- done  output  1  one-cycle pulse during the stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. State encoding and constants come from the shared include.
- Accept condition: load_valid && load_ready at a rising edge. On accept, the block captures data_in into the shift register, computes parity as the XOR of data_in, clears the bit counter, and moves to START.
- IDLE: serial_out=1, busy=0, load_ready=1.
- START: serial_out=0. Next state is DATA.
- DATA: serial_out is the current end bit of the shift register (bit 0 if MSB_FIRST=0, bit WIDTH-1 otherwise). The register shifts once per cycle and the counter increments.
  - After WIDTH cycles (counter = WIDTH-1), the next state is PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: serial_out = XOR of the captured word (even parity). Next state is STOP.
- STOP: serial_out=1, done=1, load_ready=1.
  - If a load is accepted, the next state is START (zero-gap back-to-back).
  - Otherwise the next state is IDLE.
- Outside IDLE and STOP, load_ready=0. load_valid is ignored there, and data_in changes do not affect the frame in flight.
- Bit counter width is $clog2(WIDTH). It never wraps within a frame and is cleared on accept.
- Reset: state goes to IDLE, shift register and parity register to 0, counter to 0, and serial_out is held at 1.
  - While reset is high: load_ready=0, busy=0, done=0.
  - Reset mid-frame aborts the frame immediately. The line returns to 1 on the edge where reset is sampled, and the partial frame is discarded.
- reset and load_valid asserted together: reset wins and no word is accepted.

## Timing
- Frame length is F = WIDTH + 2 + PARITY_EN cycles. Line throughput is one word per F cycles with continuous load_valid.
- Latency: if accept happens at edge N, the start bit appears on serial_out after edge N and the first data bit after edge N+1.
- serial_out, busy and done are registered; no combinational path from inputs to them.
- load_ready is decoded from state and reset only; it does not depend on load_valid.
- done is high for exactly one cycle per frame, coincident with the stop bit.

## Structure
- The shared include (tx_defs.vh) holds the state localparams (IDLE=0 through STOP=4, 3 bits) and the line-level constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- The FSM, counter, shift register and parity live in one module.
- One optional sub-module, tx_shift_reg: a WIDTH-bit loadable shift register with direction selected by MSB_FIRST. It is reusable by the matching receiver.

## Test plan
- Reset then idle: assert reset 2 cycles, release, hold load_valid=0 for 10 cycles. Required: serial_out=1, busy=0, done=0 throughout; load_ready=0 during reset and 1 afterwards.
- Single frame, defaults (WIDTH=4, PARITY_EN=1, LSB first), data_in=4'b1011 accepted. Required:
  - serial_out over the 7 cycles after accept: 0,1,1,0,1,1,1 (start, bits, parity=1, stop).
  - done is high on the 7th cycle only, and the state returns to IDLE.
- Back-to-back: load_valid held high with 4'hA then 4'h3, the second word presented during STOP. Required:
  - The second start bit immediately follows the first stop bit.
  - Line sequence: 0,0,1,0,1,0,1 then 0,1,1,0,0,0,1.
- Load ignored while busy: pulse load_valid with 4'hF in the DATA state. Required: load_ready=0, the in-flight frame is unchanged, and 4'hF is not sent.
- Reset mid-frame: assert reset during the second DATA cycle. Required: serial_out=1 on the next edge, no done pulse, and a new load after release transmits a full frame correctly.
- Variant PARITY_EN=0, MSB_FIRST=1, data_in=4'b1000. Required: 6-cycle frame 0,1,0,0,0,1, with done on the 6th cycle.

Source files
------------

// File: rtl/piso_frame_tx_pkg.sv
// Shared definitions for the parallel-in serial-out frame transmitter.
// Holds the FSM state encoding and the line-level constants. The matching
// receiver imports the same package so both ends agree on framing.
package piso_frame_tx_pkg;

  // Frame states. The 3-bit encoding is fixed so that other blocks can
  // decode the state directly.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Line levels: the line marks high when idle, a start bit pulls it low,
  // and a stop bit returns it high.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/piso_frame_tx_if.sv
// Load/line bundle for piso_frame_tx.
//   data_in    : word to transmit (WIDTH bits)
//   load_valid : data_in is valid
//   load_ready : transmitter accepts a word this cycle
//   serial_out : line output, idles high
//   busy       : a frame is on the line (START through STOP)
//   done       : one-cycle pulse during the stop bit
// master = word producer, slave = transmitter.
interface piso_frame_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in, load_valid,
    input  load_ready, serial_out, busy, done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, serial_out, busy, done
  );
endinterface

// File: rtl/piso_frame_tx.sv
// Parallel-in, serial-out frame transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake and sends it as a
// start bit, WIDTH data bits (LSB or MSB first), an optional even-parity
// bit, and a stop bit. A new word may be accepted during the stop bit, so
// frames can run back to back with no idle gap.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; aborts any frame in flight
//   bus   : piso_frame_tx_if slave modport (data_in, load_valid,
//           load_ready, serial_out, busy, done)
// Parameters:
//   WIDTH     : data word width, 2..32
//   PARITY_EN : 1 inserts an even-parity bit after the data bits
//   MSB_FIRST : 1 sends the MSB first, 0 the LSB first
module piso_frame_tx #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            reset,
  piso_frame_tx_if.slave  bus
);
  import piso_frame_tx_pkg::*;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic             par;
  logic [CNT_W-1:0] cnt;
  logic             serial_q;
  logic             busy_q;
  logic             done_q;
  logic             ready;
  logic             accept;

  // Bit currently at the transmitting end of the shift register.
  function automatic logic end_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit to the transmitting end.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready depends only on state and reset, never on load_valid.
  assign ready  = !reset && ((state == IDLE) || (state == STOP));
  assign accept = bus.load_valid && ready;

  assign bus.load_ready = ready;
  assign bus.serial_out = serial_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // Outputs are registered with the value belonging to the state being
  // entered, so each line level appears in the same cycle as its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      par      <= 1'b0;
      cnt      <= '0;
      serial_q <= LINE_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state    <= START;
        shreg    <= bus.data_in;
        par      <= ^bus.data_in;
        cnt      <= '0;
        serial_q <= START_BIT;
        busy_q   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            serial_q <= LINE_IDLE;
            busy_q   <= 1'b0;
          end
          START: begin
            state    <= DATA;
            serial_q <= end_bit(shreg);
            shreg    <= shift_once(shreg);
          end
          DATA: begin
            if (cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state    <= PARITY;
                serial_q <= par;
              end else begin
                state    <= STOP;
                serial_q <= STOP_BIT;
                done_q   <= 1'b1;
              end
            end else begin
              cnt      <= cnt + CNT_W'(1);
              serial_q <= end_bit(shreg);
              shreg    <= shift_once(shreg);
            end
          end
          PARITY: begin
            state    <= STOP;
            serial_q <= STOP_BIT;
            done_q   <= 1'b1;
          end
          default: begin
            // STOP with no new word, or an illegal encoding: back to idle.
            state    <= IDLE;
            serial_q <= LINE_IDLE;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
module tb_piso_frame_tx;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  piso_frame_tx_if #(.WIDTH(4)) bus_a ();
  piso_frame_tx_if #(.WIDTH(4)) bus_b ();

  piso_frame_tx #(.WIDTH(4), .PARITY_EN(1), .MSB_FIRST(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  piso_frame_tx #(.WIDTH(4), .PARITY_EN(0), .MSB_FIRST(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.load_valid = 1'b0;
    bus_b.load_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (bus_a.serial_out !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0
          || bus_a.load_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got line/busy/done/ready=%b%b%b%b want=1000",
                 i, bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.load_ready);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (bus_a.serial_out !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0
          || bus_a.load_ready !== 1'b1) begin
        bad++;
        $display("FAIL idle cyc=%0d got line/busy/done/ready=%b%b%b%b want=1001",
                 i, bus_a.serial_out, bus_a.busy, bus_a.done, bus_a.load_ready);
      end
      total++;
      if (bus_b.serial_out !== 1'b1 || bus_b.load_ready !== 1'b1) begin
        bad++;
        $display("FAIL idle_b cyc=%0d got line/ready=%b%b want=11",
                 i, bus_b.serial_out, bus_b.load_ready);
      end
    end
  endtask

  task automatic test_single();
    logic [6:0] exp_line;
    exp_line = 7'b0110111;
    bus_a.data_in    = 4'b1011;
    bus_a.load_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) bus_a.load_valid = 1'b0;
      total++;
      if (bus_a.serial_out !== exp_line[6-i]) begin
        bad++;
        $display("FAIL single_line bit=%0d got=%b want=%b", i, bus_a.serial_out, exp_line[6-i]);
      end
      total++;
      if (bus_a.done !== (i == 6)) begin
        bad++;
        $display("FAIL single_done cyc=%0d got=%b want=%b", i, bus_a.done, (i == 6));
      end
    end
    step();
    total++;
    if (bus_a.busy !== 1'b0 || bus_a.load_ready !== 1'b1 || bus_a.serial_out !== 1'b1
        || bus_a.done !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got busy/ready/line/done=%b%b%b%b want=0110",
               bus_a.busy, bus_a.load_ready, bus_a.serial_out, bus_a.done);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp_line;
    exp_line = 14'b0010101_0110001;
    bus_a.data_in    = 4'hA;
    bus_a.load_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      total++;
      if (bus_a.serial_out !== exp_line[13-i]) begin
        bad++;
        $display("FAIL b2b_line bit=%0d got=%b want=%b", i, bus_a.serial_out, exp_line[13-i]);
      end
      total++;
      if (bus_a.done !== (i == 6 || i == 13)) begin
        bad++;
        $display("FAIL b2b_done cyc=%0d got=%b want=%b", i, bus_a.done, (i == 6 || i == 13));
      end
      if (i == 6) begin
        total++;
        if (bus_a.load_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready_stop got=%b want=1", bus_a.load_ready);
        end
        bus_a.data_in = 4'h3;
      end
      if (i == 13) bus_a.load_valid = 1'b0;
    end
    step();
    total++;
    if (bus_a.busy !== 1'b0 || bus_a.serial_out !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle got busy/line=%b%b want=01", bus_a.busy, bus_a.serial_out);
    end
  endtask

  task automatic test_busy_ignore();
    logic [6:0] exp_line;
    exp_line = 7'b0101001;
    bus_a.data_in    = 4'b0101;
    bus_a.load_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) bus_a.load_valid = 1'b0;
      total++;
      if (bus_a.serial_out !== exp_line[6-i]) begin
        bad++;
        $display("FAIL ignore_line bit=%0d got=%b want=%b", i, bus_a.serial_out, exp_line[6-i]);
      end
      if (i == 1) begin
        bus_a.data_in    = 4'hF;
        bus_a.load_valid = 1'b1;
        #1;
        total++;
        if (bus_a.load_ready !== 1'b0) begin
          bad++;
          $display("FAIL ignore_ready got=%b want=0", bus_a.load_ready);
        end
      end
      if (i == 2) begin
        bus_a.load_valid = 1'b0;
        bus_a.data_in    = 4'h0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus_a.busy !== 1'b0 || bus_a.serial_out !== 1'b1) begin
        bad++;
        $display("FAIL ignore_after cyc=%0d got busy/line=%b%b want=01",
                 i, bus_a.busy, bus_a.serial_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp_line;
    bus_a.data_in    = 4'b0110;
    bus_a.load_valid = 1'b1;
    step();
    bus_a.load_valid = 1'b0;
    step();
    step();
    total++;
    if (bus_a.busy !== 1'b1) begin
      bad++;
      $display("FAIL rmid_inflight got busy=%b want=1", bus_a.busy);
    end
    reset = 1'b1;
    step();
    total++;
    if (bus_a.serial_out !== 1'b1 || bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_abort got line/done/busy=%b%b%b want=100",
               bus_a.serial_out, bus_a.done, bus_a.busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus_a.serial_out !== 1'b1 || bus_a.done !== 1'b0) begin
        bad++;
        $display("FAIL rmid_quiet cyc=%0d got line/done=%b%b want=10",
                 i, bus_a.serial_out, bus_a.done);
      end
    end
    exp_line = 7'b0100101;
    bus_a.data_in    = 4'b1001;
    bus_a.load_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) bus_a.load_valid = 1'b0;
      total++;
      if (bus_a.serial_out !== exp_line[6-i] || bus_a.done !== (i == 6)) begin
        bad++;
        $display("FAIL rmid_reload bit=%0d got line/done=%b%b want=%b%b",
                 i, bus_a.serial_out, bus_a.done, exp_line[6-i], (i == 6));
      end
    end
  endtask

  task automatic test_variant();
    logic [5:0] exp_line;
    exp_line = 6'b010001;
    bus_b.data_in    = 4'b1000;
    bus_b.load_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) bus_b.load_valid = 1'b0;
      total++;
      if (bus_b.serial_out !== exp_line[5-i]) begin
        bad++;
        $display("FAIL variant_line bit=%0d got=%b want=%b", i, bus_b.serial_out, exp_line[5-i]);
      end
      total++;
      if (bus_b.done !== (i == 5)) begin
        bad++;
        $display("FAIL variant_done cyc=%0d got=%b want=%b", i, bus_b.done, (i == 5));
      end
    end
    step();
    total++;
    if (bus_b.busy !== 1'b0 || bus_b.serial_out !== 1'b1) begin
      bad++;
      $display("FAIL variant_idle got busy/line=%b%b want=01", bus_b.busy, bus_b.serial_out);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus_a.data_in    = '0;
    bus_a.load_valid = 1'b0;
    bus_b.data_in    = '0;
    bus_b.load_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_variant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
